// File: rtl/mpi_eth_pkg.sv
// Shared definitions for the MPI-over-Ethernet receive path: parser states,
// header field positions and protocol constants.
package mpi_eth_pkg;

    typedef enum logic [2:0] {
        ST_H0   = 3'd0,
        ST_H1   = 3'd1,
        ST_H2   = 3'd2,
        ST_H3   = 3'd3,
        ST_META = 3'd4,
        ST_PAY  = 3'd5,
        ST_DROP = 3'd6
    } parser_state_t;

    localparam logic [47:0] MAC_ADDR_DEFAULT      = 48'hfa163e55ca02;
    localparam logic [15:0] ETHERTYPE_MPI_DEFAULT = 16'h7400;

    // Beat 0: destination MAC
    localparam int DST_MAC_LSB = 0;
    localparam int DST_MAC_W   = 48;
    // Beat 1: ethertype
    localparam int ETYPE_LSB   = 32;
    localparam int ETYPE_W     = 16;
    // Beat 3: MPI header
    localparam int DST_RANK_LSB = 0;
    localparam int DST_RANK_W   = 16;
    localparam int SRC_RANK_LSB = 16;
    localparam int SRC_RANK_W   = 8;
    localparam int OPCODE_LSB   = 24;
    localparam int OPCODE_W     = 8;
    localparam int SIZE_LSB     = 32;
    localparam int SIZE_W       = 32;

    localparam logic [7:0] OPCODE_SEND = 8'h01;
    localparam logic [7:0] OPCODE_DONE = 8'h02;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hffff)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/mpi_eth_rx_parser.sv
// Strips the Ethernet/IP/MPI headers from an incoming frame stream, presents the
// MPI header as a sideband record and forwards the payload with zero latency.
module mpi_eth_rx_parser
    import mpi_eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR_FPGA = MAC_ADDR_DEFAULT,
    parameter logic [15:0] ETHERTYPE_MPI = ETHERTYPE_MPI_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [63:0]   stream_in_DATA,
    input  logic [7:0]    stream_in_KEEP,
    input  logic          stream_in_LAST,
    input  logic          stream_in_VALID,
    output logic          stream_in_READY,

    output logic [63:0]   stream_out_DATA,
    output logic [7:0]    stream_out_KEEP,
    output logic          stream_out_LAST,
    output logic          stream_out_VALID,
    input  logic          stream_out_READY,

    output logic [15:0]   meta_dst_rank,
    output logic [7:0]    meta_src_rank,
    output logic [7:0]    meta_opcode,
    output logic [31:0]   meta_size,
    output logic          meta_empty,
    output logic          meta_valid,
    input  logic          meta_ready,

    output logic [15:0]   cnt_ok,
    output logic [15:0]   cnt_drop,
    output logic [15:0]   cnt_short,

    output parser_state_t fsm_state
);

    // Handshake rule on every port: a beat or record moves on a rising clk edge
    // where VALID and READY are both high; the producer holds its outputs until then.

    parser_state_t state;
    logic          mac_ok;
    logic          in_fire;
    logic          meta_fire;
    logic          hdr_bad;
    logic          ok_inc;
    logic          drop_inc;
    logic          short_inc;

    assign fsm_state = state;

    always_comb begin
        stream_in_READY = 1'b1;
        case (state)
            ST_META: stream_in_READY = 1'b0;
            ST_PAY:  stream_in_READY = stream_out_READY;
            default: stream_in_READY = 1'b1;
        endcase
    end

    assign in_fire   = stream_in_VALID && stream_in_READY;
    assign meta_fire = meta_valid && meta_ready;
    assign hdr_bad   = !mac_ok ||
                       (stream_in_DATA[ETYPE_LSB +: ETYPE_W] != ETHERTYPE_MPI);

    // Payload passes straight through; only VALID is gated by the parser state.
    assign stream_out_DATA  = stream_in_DATA;
    assign stream_out_KEEP  = stream_in_KEEP;
    assign stream_out_LAST  = stream_in_LAST;
    assign stream_out_VALID = (state == ST_PAY) && stream_in_VALID;

    assign ok_inc = ((state == ST_META) && meta_fire && meta_empty) ||
                    ((state == ST_PAY) && in_fire && stream_in_LAST);

    assign drop_inc = in_fire && stream_in_LAST &&
                      ((state == ST_DROP) || ((state == ST_H1) && hdr_bad));

    assign short_inc = in_fire && stream_in_LAST &&
                       ((state == ST_H0) || (state == ST_H2) ||
                        ((state == ST_H1) && !hdr_bad));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_H0;
            mac_ok        <= 1'b0;
            meta_dst_rank <= '0;
            meta_src_rank <= '0;
            meta_opcode   <= '0;
            meta_size     <= '0;
            meta_empty    <= 1'b0;
            meta_valid    <= 1'b0;
        end else begin
            case (state)
                ST_H0: begin
                    if (in_fire) begin
                        mac_ok <= (stream_in_DATA[DST_MAC_LSB +: DST_MAC_W] == MAC_ADDR_FPGA);
                        if (!stream_in_LAST) state <= ST_H1;
                    end
                end
                ST_H1: begin
                    if (in_fire) begin
                        if (stream_in_LAST)  state <= ST_H0;
                        else if (hdr_bad)    state <= ST_DROP;
                        else                 state <= ST_H2;
                    end
                end
                ST_H2: begin
                    if (in_fire) state <= stream_in_LAST ? ST_H0 : ST_H3;
                end
                ST_H3: begin
                    if (in_fire) begin
                        meta_dst_rank <= stream_in_DATA[DST_RANK_LSB +: DST_RANK_W];
                        meta_src_rank <= stream_in_DATA[SRC_RANK_LSB +: SRC_RANK_W];
                        meta_opcode   <= stream_in_DATA[OPCODE_LSB +: OPCODE_W];
                        meta_size     <= stream_in_DATA[SIZE_LSB +: SIZE_W];
                        meta_empty    <= stream_in_LAST;
                        meta_valid    <= 1'b1;
                        state         <= ST_META;
                    end
                end
                ST_META: begin
                    if (meta_fire) begin
                        meta_valid <= 1'b0;
                        state      <= meta_empty ? ST_H0 : ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (in_fire && stream_in_LAST) state <= ST_H0;
                end
                ST_DROP: begin
                    if (in_fire && stream_in_LAST) state <= ST_H0;
                end
                default: state <= ST_H0;
            endcase
        end
    end

    sat_counter16 u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_inc),
        .count (cnt_ok)
    );

    sat_counter16 u_cnt_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (cnt_drop)
    );

    sat_counter16 u_cnt_short (
        .clk   (clk),
        .rst   (rst),
        .inc   (short_inc),
        .count (cnt_short)
    );

endmodule

// File: tb/tb_mpi_eth_rx_parser.sv
// Randomised scoreboard bench for mpi_eth_rx_parser: a frame-level model predicts
// meta records, payload beats and counters; a monitor checks what the DUT emits.
module tb_mpi_eth_rx_parser;
    import mpi_eth_pkg::*;

    localparam logic [47:0] MAC     = 48'hfa163e55ca02;
    localparam logic [47:0] BAD_MAC = 48'h0cc47a88c047;
    localparam logic [15:0] ETH     = 16'h7400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   stream_in_DATA = '0;
    logic [7:0]    stream_in_KEEP = '0;
    logic          stream_in_LAST = 1'b0;
    logic          stream_in_VALID = 1'b0;
    logic          stream_in_READY;
    logic [63:0]   stream_out_DATA;
    logic [7:0]    stream_out_KEEP;
    logic          stream_out_LAST;
    logic          stream_out_VALID;
    logic          stream_out_READY = 1'b1;
    logic [15:0]   meta_dst_rank;
    logic [7:0]    meta_src_rank;
    logic [7:0]    meta_opcode;
    logic [31:0]   meta_size;
    logic          meta_empty;
    logic          meta_valid;
    logic          meta_ready = 1'b1;
    logic [15:0]   cnt_ok, cnt_drop, cnt_short;
    parser_state_t fsm_state;

    mpi_eth_rx_parser dut (
        .clk              (clk),
        .rst              (rst),
        .stream_in_DATA   (stream_in_DATA),
        .stream_in_KEEP   (stream_in_KEEP),
        .stream_in_LAST   (stream_in_LAST),
        .stream_in_VALID  (stream_in_VALID),
        .stream_in_READY  (stream_in_READY),
        .stream_out_DATA  (stream_out_DATA),
        .stream_out_KEEP  (stream_out_KEEP),
        .stream_out_LAST  (stream_out_LAST),
        .stream_out_VALID (stream_out_VALID),
        .stream_out_READY (stream_out_READY),
        .meta_dst_rank    (meta_dst_rank),
        .meta_src_rank    (meta_src_rank),
        .meta_opcode      (meta_opcode),
        .meta_size        (meta_size),
        .meta_empty       (meta_empty),
        .meta_valid       (meta_valid),
        .meta_ready       (meta_ready),
        .cnt_ok           (cnt_ok),
        .cnt_drop         (cnt_drop),
        .cnt_short        (cnt_short),
        .fsm_state        (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [64:0] exp_meta_q[$];   // {dst_rank, src_rank, opcode, size, empty}
    logic [72:0] exp_pay_q[$];    // {data, keep, last}
    int m_ok = 0, m_drop = 0, m_short = 0;
    logic [63:0] fd[$];
    logic [7:0]  fk[$];
    int  rdy_mode = 0;            // 0: always ready, 1: random, 2: toggle out / hold meta
    bit  gaps = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- sink ready drivers ----------------
    initial begin
        int mwait = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    stream_out_READY = ($urandom_range(0, 3) != 0);
                    meta_ready       = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    stream_out_READY = ~stream_out_READY;
                    if (meta_valid) mwait++; else mwait = 0;
                    meta_ready = (mwait > 5);
                end
                default: begin
                    stream_out_READY = 1'b1;
                    meta_ready       = 1'b1;
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic        hold_flag = 1'b0;
    logic [64:0] hold_meta;
    always @(negedge clk) begin
        logic [64:0] gm;
        logic [72:0] gp;
        if (!rst) begin
            gm = {meta_dst_rank, meta_src_rank, meta_opcode, meta_size, meta_empty};
            if (hold_flag && meta_valid) check("meta_stable", 80'(gm), 80'(hold_meta));
            hold_flag = meta_valid && !meta_ready;
            hold_meta = gm;
            if (meta_valid && meta_ready) begin
                if (exp_meta_q.size() == 0) check("meta_unexpected", 80'(gm), 80'hdead);
                else check("meta", 80'(gm), 80'(exp_meta_q.pop_front()));
            end
            if (stream_out_VALID && stream_out_READY) begin
                gp = {stream_out_DATA, stream_out_KEEP, stream_out_LAST};
                if (exp_pay_q.size() == 0) check("pay_unexpected", 80'(gp), 80'hdead);
                else check("pay", 80'(gp), 80'(exp_pay_q.pop_front()));
            end
        end else begin
            hold_flag = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    task automatic model_frame();
        int   n = fd.size();
        bit   mac_ok = (fd[0][47:0] == MAC);
        bit   type_ok = (n > 1) && (fd[1][47:32] == ETH);
        if (n == 1) m_short++;
        else if (!(mac_ok && type_ok)) m_drop++;
        else if (n < 4) m_short++;
        else begin
            exp_meta_q.push_back({fd[3][15:0], fd[3][23:16], fd[3][31:24], fd[3][63:32], n == 4});
            for (int i = 4; i < n; i++) exp_pay_q.push_back({fd[i], fk[i], i == n - 1});
            m_ok++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [15:0] dr,
                         input logic [7:0] sr, input logic [7:0] op, input logic [31:0] sz,
                         input int npay, input int fixed_pay, input int trunc);
        logic [47:0] smac = 48'({$urandom, $urandom});
        fd.delete(); fk.delete();
        fd.push_back({smac[15:0], dmac});
        fd.push_back({16'($urandom), et, smac[47:16]});
        fd.push_back({$urandom, $urandom});
        fd.push_back({sz, op, sr, dr});
        repeat (4) fk.push_back(8'hff);
        for (int i = 0; i < npay; i++) begin
            fd.push_back(fixed_pay >= 0 ? 64'(fixed_pay) : {$urandom, $urandom});
            fk.push_back(fixed_pay >= 0 ? 8'hff : 8'($urandom_range(1, 255)));
        end
        if (trunc > 0) while (fd.size() > trunc) begin void'(fd.pop_back()); void'(fk.pop_back()); end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        stream_in_DATA = d; stream_in_KEEP = k; stream_in_LAST = l; stream_in_VALID = 1'b1;
        forever begin
            @(negedge clk);
            if (stream_in_READY) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
            t++;
            if (t > 300) begin check("in_ready_timeout", 80'(t), 80'(0)); break; end
        end
        stream_in_VALID = 1'b0;
    endtask

    task automatic send_frame();
        model_frame();
        for (int i = 0; i < fd.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_beat(fd[i], fk[i], i == fd.size() - 1);
        end
    endtask

    task automatic drain_and_check(input string tag);
        int t = 0;
        while ((exp_meta_q.size() != 0 || exp_pay_q.size() != 0) && t < 2000) begin
            @(posedge clk); t++;
        end
        check({tag, "_drain_left"}, 80'(exp_meta_q.size() + exp_pay_q.size()), 80'(0));
        exp_meta_q.delete(); exp_pay_q.delete();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_cnt_ok"},    80'(cnt_ok),    80'(m_ok));
        check({tag, "_cnt_drop"},  80'(cnt_drop),  80'(m_drop));
        check({tag, "_cnt_short"}, 80'(cnt_short), 80'(m_short));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},   80'(stream_in_READY),  80'(1));
        check({tag, "_out_valid"},  80'(stream_out_VALID), 80'(0));
        check({tag, "_meta_valid"}, 80'(meta_valid),       80'(0));
        check({tag, "_meta_fields"},
              80'({meta_dst_rank, meta_src_rank, meta_opcode, meta_size, meta_empty}), 80'(0));
        check({tag, "_counters"},   80'({cnt_ok, cnt_drop, cnt_short}), 80'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference frame: 11 payload beats of 13
        build(MAC, ETH, 16'd0, 8'd1, OPCODE_SEND, 32'd2, 11, 13, 0);
        send_frame();
        drain_and_check("basic");

        // Foreign MAC dropped, then a good frame right behind it
        build(BAD_MAC, ETH, 16'd3, 8'd4, OPCODE_SEND, 32'd9, 3, -1, 0);
        send_frame();
        build(MAC, ETH, 16'd5, 8'd6, OPCODE_SEND, 32'd2, 2, -1, 0);
        send_frame();
        drain_and_check("drop");

        // LAST on beat1, next beat is beat0 of a new frame
        build(MAC, ETH, 16'd1, 8'd1, OPCODE_SEND, 32'd1, 4, -1, 2);
        send_frame();
        build(MAC, ETH, 16'd7, 8'd2, OPCODE_SEND, 32'd3, 3, -1, 0);
        send_frame();
        drain_and_check("short");

        // Back-pressure: toggling out ready, meta held off several cycles
        rdy_mode = 2;
        build(MAC, ETH, 16'h1234, 8'h56, OPCODE_SEND, 32'd88, 11, -1, 0);
        send_frame();
        drain_and_check("stall");
        rdy_mode = 0;

        // Header-only DONE frame
        build(MAC, ETH, 16'd9, 8'd3, OPCODE_DONE, 32'd0, 0, -1, 0);
        send_frame();
        drain_and_check("done");

        // Randomised mix
        rdy_mode = 1;
        gaps = 1;
        for (int f = 0; f < 40; f++) begin
            logic [47:0] dm = ($urandom_range(0, 9) < 8) ? MAC : 48'({$urandom, $urandom});
            logic [15:0] et = ($urandom_range(0, 9) < 8) ? ETH : 16'($urandom);
            int tr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
            build(dm, et, 16'($urandom), 8'($urandom), 8'($urandom_range(1, 2)),
                  $urandom, $urandom_range(0, 8), -1, tr);
            send_frame();
        end
        drain_and_check("random");
        rdy_mode = 0;
        gaps = 0;

        // Reset during payload beat 5
        build(MAC, ETH, 16'd2, 8'd2, OPCODE_SEND, 32'd8, 8, -1, 0);
        model_frame();
        for (int i = 0; i < 8; i++) send_beat(fd[i], fk[i], 1'b0);
        stream_in_DATA = fd[8]; stream_in_KEEP = fk[8]; stream_in_LAST = 1'b0; stream_in_VALID = 1'b1;
        rst = 1'b1;
        exp_pay_q.delete();
        m_ok = 0; m_drop = 0; m_short = 0;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        stream_in_VALID = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        build(MAC, ETH, 16'd11, 8'd12, OPCODE_SEND, 32'd5, 5, -1, 0);
        send_frame();
        drain_and_check("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
